dispense_sequencer: RTL and testbench

- Sequences one dispense of the vending datapath: drives the slot motor, watches the IR drop sensor, retries on timeout, sounds the completion buzzer, and raises a refund request on failure.
- Sits between the top-level FSM and the motor, IR and buzzer drivers.
- The top-level FSM issues `start` in its DISPENSE state and waits for `done` or `fail`.

---
 rtl/dispense_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_dispense_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_sequencer.sv
// dispense_sequencer: runs one vend (motor spin, IR drop detect, retry, chime, refund on failure).
// Optional build macro JAM_REVERSE_EN: drive the slot in reverse during the pause between attempts.
module dispense_sequencer #(
    parameter int MOTOR_TIMEOUT = 5000,
    parameter int MAX_RETRIES   = 2,
    parameter int SETTLE_CYCLES = 100,
    parameter int BUZZ_CYCLES   = 1000,
    parameter int DEBOUNCE      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] item_code,
    input  logic       ir_in,
    input  logic       refund_ack,
    output logic       busy,
    output logic       motor_en,
    output logic [3:0] motor_sel,
    output logic       motor_dir,
    output logic       buzzer_en,
    output logic       done,
    output logic       fail,
    output logic       refund_req,
    output logic [1:0] attempts
);

    localparam int MAX_SB  = (SETTLE_CYCLES > BUZZ_CYCLES) ? SETTLE_CYCLES : BUZZ_CYCLES;
    localparam int MAX_CNT = (MOTOR_TIMEOUT > MAX_SB) ? MOTOR_TIMEOUT : MAX_SB;
    localparam int TIMER_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int DEB_W   = $clog2(DEBOUNCE + 1);

    localparam logic [TIMER_W-1:0] SPIN_LAST   = TIMER_W'(MOTOR_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] BUZZ_LAST   = TIMER_W'(BUZZ_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_MAX     = DEB_W'(DEBOUNCE);

    typedef enum logic [2:0] {
        IDLE,
        SPIN,
        SETTLE,
        CHIME,
        FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         attempts_q, attempts_d;
    logic [1:0]         item_q, item_d;
    logic [1:0]         sync_q, sync_d;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic               det;
    logic               retry_ok;

    logic               busy_q, busy_d;
    logic               motor_en_q, motor_en_d;
    logic [3:0]         motor_sel_q, motor_sel_d;
    logic               buzzer_en_q, buzzer_en_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic               refund_req_q, refund_req_d;
`ifdef JAM_REVERSE_EN
    logic               motor_dir_q, motor_dir_d;
`endif

    assign det      = (deb_q == DEB_MAX);
    assign retry_ok = (int'(attempts_q) < MAX_RETRIES) && (attempts_q != 2'b11);

    always_comb begin
        sync_d = {sync_q[0], ir_in};
        if (!sync_q[1]) begin
            deb_d = '0;
        end else if (deb_q == DEB_MAX) begin
            deb_d = deb_q;
        end else begin
            deb_d = deb_q + DEB_W'(1);
        end

        state_d    = state_q;
        timer_d    = timer_q;
        attempts_d = attempts_q;
        item_d     = item_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    item_d     = item_code;
                    attempts_d = '0;
                    timer_d    = '0;
                    state_d    = det ? FAULT : SPIN;
                end
            end
            SPIN: begin
                // A drop seen on the timeout cycle still counts as success.
                if (det) begin
                    state_d = CHIME;
                    timer_d = '0;
                end else if (timer_q == SPIN_LAST) begin
                    timer_d = '0;
                    if (retry_ok) begin
                        state_d    = SETTLE;
                        attempts_d = attempts_q + 2'd1;
                    end else begin
                        state_d = FAULT;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            SETTLE: begin
                if (det) begin
                    state_d = CHIME;
                    timer_d = '0;
                end else if (timer_q == SETTLE_LAST) begin
                    state_d = SPIN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            CHIME: begin
                if (timer_q == BUZZ_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            FAULT: begin
                if (refund_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it after the edge.
        busy_d       = (state_d != IDLE);
`ifdef JAM_REVERSE_EN
        motor_en_d   = (state_d == SPIN) || (state_d == SETTLE);
        motor_dir_d  = (state_d == SETTLE);
`else
        motor_en_d   = (state_d == SPIN);
`endif
        motor_sel_d  = motor_en_d ? (4'b0001 << item_d) : 4'b0000;
        buzzer_en_d  = (state_d == CHIME);
        done_d       = (state_d == CHIME) && (timer_d == BUZZ_LAST);
        fail_d       = (state_d == FAULT) && (state_q != FAULT);
        refund_req_d = (state_d == FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            attempts_q   <= '0;
            item_q       <= '0;
            sync_q       <= '0;
            deb_q        <= '0;
            busy_q       <= 1'b0;
            motor_en_q   <= 1'b0;
            motor_sel_q  <= '0;
            buzzer_en_q  <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            refund_req_q <= 1'b0;
`ifdef JAM_REVERSE_EN
            motor_dir_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            attempts_q   <= attempts_d;
            item_q       <= item_d;
            sync_q       <= sync_d;
            deb_q        <= deb_d;
            busy_q       <= busy_d;
            motor_en_q   <= motor_en_d;
            motor_sel_q  <= motor_sel_d;
            buzzer_en_q  <= buzzer_en_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            refund_req_q <= refund_req_d;
`ifdef JAM_REVERSE_EN
            motor_dir_q  <= motor_dir_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign motor_en   = motor_en_q;
    assign motor_sel  = motor_sel_q;
    assign buzzer_en  = buzzer_en_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign refund_req = refund_req_q;
    assign attempts   = attempts_q;
`ifdef JAM_REVERSE_EN
    assign motor_dir  = motor_dir_q;
`else
    assign motor_dir  = 1'b0;
`endif

endmodule

// File: tb/tb_dispense_sequencer.sv
// tb_dispense_sequencer: directed table, hand sequences and randomized vends for dispense_sequencer.
// Honors JAM_REVERSE_EN when it is defined for the build.
module tb_dispense_sequencer;

    localparam int T    = 20;
    localparam int S    = 4;
    localparam int B    = 5;
    localparam int DEB  = 3;
    localparam int R    = 2;
    localparam int LAST = R * (T + S) + T;
`ifdef JAM_REVERSE_EN
    localparam bit JAM = 1'b1;
`else
    localparam bit JAM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] item_code;
    logic       ir_in;
    logic       refund_ack;
    logic       busy, motor_en, motor_dir, buzzer_en, done, fail, refund_req;
    logic [3:0] motor_sel;
    logic [1:0] attempts;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic       busy;
        logic       motor;
        logic [3:0] sel;
        logic       dir;
        logic       buzz;
        logic       done;
        logic       fail;
        logic       refund;
        logic [1:0] att;
    } outs_t;

    typedef struct {
        int item;
        int ir_on;
        int glitch_at;
        int ack_at;
        int exp_first_motor;
        int exp_spin;
        int exp_settle;
        int exp_buzz;
        int exp_done;
        int exp_fail;
        int exp_att;
        int exp_refund;
        int exp_end;
    } row_t;

    bit irv [0:127];

    dispense_sequencer #(
        .MOTOR_TIMEOUT(T),
        .MAX_RETRIES  (R),
        .SETTLE_CYCLES(S),
        .BUZZ_CYCLES  (B),
        .DEBOUNCE     (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .item_code (item_code),
        .ir_in     (ir_in),
        .refund_ack(refund_ack),
        .busy      (busy),
        .motor_en  (motor_en),
        .motor_sel (motor_sel),
        .motor_dir (motor_dir),
        .buzzer_en (buzzer_en),
        .done      (done),
        .fail      (fail),
        .refund_req(refund_req),
        .attempts  (attempts)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] it, input logic ir, input logic ack);
        start      = s;
        item_code  = it;
        ir_in      = ir;
        refund_ack = ack;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic outs_t dut_out();
        outs_t o;
        o.busy   = busy;
        o.motor  = motor_en;
        o.sel    = motor_sel;
        o.dir    = motor_dir;
        o.buzz   = buzzer_en;
        o.done   = done;
        o.fail   = fail;
        o.refund = refund_req;
        o.att    = attempts;
        return o;
    endfunction

    // Number of retries already started when c cycles have elapsed since the start.
    function automatic int att_at(int c);
        return (c - 1) / (T + S) + ((((c - 1) % (T + S)) >= T) ? 1 : 0);
    endfunction

    // Expected outputs c cycles after start, given first detection td and ack cycle ta.
    function automatic outs_t model_out(int c, int td, int ta, int item);
        outs_t o;
        bit    success;
        bit    spin;
        int    f;
        o       = '0;
        success = (td >= 1) && (td <= LAST);
        f       = (td == 0) ? 1 : LAST + 1;
        if (success && c > td) begin
            o.att = 2'(att_at(td));
            if (c <= td + B) begin
                o.busy = 1'b1;
                o.buzz = 1'b1;
                o.done = (c == td + B);
            end
        end else if (!success && c >= f) begin
            o.att = (td == 0) ? 2'd0 : 2'(R);
            if (c <= ta) begin
                o.busy   = 1'b1;
                o.refund = 1'b1;
                o.fail   = (c == f);
            end
        end else begin
            spin    = (((c - 1) % (T + S)) < T);
            o.busy  = 1'b1;
            o.att   = 2'(att_at(c));
            o.motor = spin || JAM;
            o.dir   = !spin && JAM;
            o.sel   = o.motor ? 4'(1 << item) : 4'd0;
        end
        return o;
    endfunction

    function automatic bit det_at(int t);
        for (int j = 0; j < DEB; j++) begin
            if (!irv[t - 3 - j + 8]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic ir_for(row_t r, int c);
        return (c >= r.ir_on) || (r.glitch_at >= 0 && (c == r.glitch_at || c == r.glitch_at + 1));
    endfunction

    task automatic runRow(input row_t r, input int idx);
        int motor_cnt = 0, dir_cnt = 0, buzz_cnt = 0, refund_cnt = 0, sel_bad = 0, overlap = 0;
        int done_cyc = -1, fail_cyc = -1, done_cnt = 0, fail_cnt = 0;
        int first_motor = -1, end_cyc = -1, att_end = -1;
        logic [3:0] exp_sel;
        for (int c = -8; c < 0; c++) begin
            tick();
            applyStimulus(1'b0, 2'(r.item), ir_for(r, c), 1'b0);
        end
        tick();
        applyStimulus(1'b1, 2'(r.item), ir_for(r, 0), 1'b0);
        for (int c = 1; c <= 100 && end_cyc < 0; c++) begin
            tick();
            exp_sel = motor_en ? 4'(1 << r.item) : 4'd0;
            if (motor_sel !== exp_sel) sel_bad++;
            if (motor_en) begin
                motor_cnt++;
                if (first_motor < 0) first_motor = c;
            end
            if (motor_dir) dir_cnt++;
            if (buzzer_en) buzz_cnt++;
            if (refund_req) refund_cnt++;
            if (done && fail) overlap++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (fail) begin
                fail_cnt++;
                if (fail_cyc < 0) fail_cyc = c;
            end
            if (!busy) begin
                end_cyc = c;
                att_end = int'(attempts);
            end
            applyStimulus(1'b0, 2'(r.item) ^ 2'b11, ir_for(r, c), (c == r.ack_at));
        end
        applyStimulus(1'b0, 2'(r.item), 1'b0, 1'b0);
        checkOutput($sformatf("row%0d first_motor", idx), first_motor, r.exp_first_motor);
        checkOutput($sformatf("row%0d motor_cycles", idx), motor_cnt, r.exp_spin + (JAM ? r.exp_settle : 0));
        checkOutput($sformatf("row%0d dir_cycles", idx), dir_cnt, JAM ? r.exp_settle : 0);
        checkOutput($sformatf("row%0d buzz_cycles", idx), buzz_cnt, r.exp_buzz);
        checkOutput($sformatf("row%0d done_cycle", idx), done_cyc, r.exp_done);
        checkOutput($sformatf("row%0d done_count", idx), done_cnt, (r.exp_done >= 0) ? 1 : 0);
        checkOutput($sformatf("row%0d fail_cycle", idx), fail_cyc, r.exp_fail);
        checkOutput($sformatf("row%0d fail_count", idx), fail_cnt, (r.exp_fail >= 0) ? 1 : 0);
        checkOutput($sformatf("row%0d attempts", idx), att_end, r.exp_att);
        checkOutput($sformatf("row%0d refund_cycles", idx), refund_cnt, r.exp_refund);
        checkOutput($sformatf("row%0d end_cycle", idx), end_cyc, r.exp_end);
        checkOutput($sformatf("row%0d sel_errors", idx), sel_bad, 0);
        checkOutput($sformatf("row%0d done_fail_overlap", idx), overlap, 0);
    endtask

    task automatic idle_gap();
        for (int c = 0; c < 8; c++) begin
            tick();
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic reset_mid_spin();
        idle_gap();
        tick();
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        for (int c = 1; c <= 30; c++) begin
            tick();
            applyStimulus(1'b0, 2'd1, 1'b0, 1'b0);
        end
        checkOutput("pre_reset motor_en", int'(motor_en), 1);
        checkOutput("pre_reset attempts", int'(attempts), 1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset motor_en", int'(motor_en), 0);
        checkOutput("async_reset busy", int'(busy), 0);
        checkOutput("async_reset attempts", int'(attempts), 0);
        checkOutput("async_reset motor_sel", int'(motor_sel), 0);
        #1;
        reset = 1'b0;
        tick();
        tick();
        checkOutput("post_reset busy", int'(busy), 0);
    endtask

    task automatic start_during_chime();
        idle_gap();
        tick();
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            applyStimulus(c >= 12, (c >= 12) ? 2'd3 : 2'd2, c >= 6, 1'b0);
        end
        checkOutput("chime_start done", int'(done), 1);
        applyStimulus(1'b0, 2'd3, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("chime_start busy", int'(busy), 0);
        checkOutput("chime_start motor_en", int'(motor_en), 0);
        checkOutput("chime_start attempts", int'(attempts), 0);
        for (int c = 0; c < 4; c++) tick();
        checkOutput("chime_start busy_later", int'(busy), 0);
    endtask

    task automatic random_vend(input int n);
        int  item, kind, d, td, ta, f, e, lim, c;
        bit  success;
        for (int i = 0; i < 128; i++) irv[i] = 1'b0;
        item = $urandom_range(0, 3);
        kind = $urandom_range(0, 9);
        d    = 1000;
        if (kind == 0) begin
            for (int i = 2; i < 128; i++) irv[i] = 1'b1;
        end else begin
            if (kind >= 3) d = $urandom_range(1, LAST + 3);
            lim = (d < 110) ? d : 110;
            c = 1;
            while (c < lim) begin
                if ($urandom_range(0, 7) == 0 && c + 2 < lim) begin
                    irv[c + 8]     = 1'b1;
                    irv[c + 9]     = 1'b1;
                    c += 3;
                end else begin
                    c++;
                end
            end
            for (int i = d; i < 120; i++) irv[i + 8] = 1'b1;
        end
        td = 1000;
        for (int t = 0; t <= LAST; t++) begin
            if (det_at(t)) begin
                td = t;
                break;
            end
        end
        success = (td >= 1) && (td <= LAST);
        f  = (td == 0) ? 1 : LAST + 1;
        ta = success ? -1 : f + $urandom_range(0, 5);
        e  = success ? td + B + 1 : ta + 1;
        for (int k = -8; k < 0; k++) begin
            tick();
            applyStimulus(1'b0, 2'($urandom_range(0, 3)), irv[k + 8], 1'($urandom_range(0, 1)));
        end
        tick();
        applyStimulus(1'b1, 2'(item), irv[8], 1'b0);
        for (int k = 1; k <= e; k++) begin
            tick();
            checkOutput($sformatf("rand%0d c%0d", n, k), int'(dut_out()), int'(model_out(k, td, ta, item)));
            if (k < e) begin
                applyStimulus($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), irv[k + 8],
                              (k == ta) || ((success || k < f) && $urandom_range(0, 3) == 0));
            end else begin
                applyStimulus(1'b0, 2'(item), 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        row_t rows [8];
        rows[0] = '{2, 6,   -1, -1,  1, 11, 0, 5, 16, -1, 0, 0, 17};
        rows[1] = '{1, 30,  -1, -1,  1, 31, 4, 5, 40, -1, 1, 0, 41};
        rows[2] = '{3, 999, -1, 72,  1, 60, 8, 0, -1, 69, 2, 4, 73};
        rows[3] = '{0, -6,  -1, 3,  -1, 0,  0, 0, -1, 1,  0, 3, 4};
        rows[4] = '{2, 10,   5, -1,  1, 15, 0, 5, 20, -1, 0, 0, 21};
        rows[5] = '{1, 17,  -1, -1,  1, 20, 2, 5, 27, -1, 1, 0, 28};
        rows[6] = '{3, 15,  -1, -1,  1, 20, 0, 5, 25, -1, 0, 0, 26};
        rows[7] = '{0, 63,  -1, -1,  1, 60, 8, 5, 73, -1, 2, 0, 74};

        reset = 1'b1;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkOutput("reset_state", int'(dut_out()), 0);

        for (int i = 0; i < 8; i++) runRow(rows[i], i);

        reset_mid_spin();
        start_during_chime();

        for (int n = 0; n < 30; n++) random_vend(n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
